// File: rtl/pi_spi_pkg.sv
// Shared types for the Pi voltage-link SPI initiator.
// Frame width default and FSM state encoding.
package pi_spi_pkg;

    localparam int PI_SPI_WIDTH  = 8;
    localparam int PI_SPI_CLKDIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } spi_state_t;

endpackage

// File: rtl/pi_spi_tick.sv
// Phase timer for the SPI initiator.
// Counts 0..CLKDIV-1 per sclk phase while a frame runs.
module pi_spi_tick
    import pi_spi_pkg::*;
#(
    parameter int CLKDIV = PI_SPI_CLKDIV
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_done
);

    logic [7:0] r_cnt;

    assign o_done = (r_cnt == 8'(CLKDIV - 1));

    // Restart at every phase boundary; parked at zero while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (!i_run || o_done) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pi_spi_master.sv
// SPI mode-0 initiator toward the Pi voltage-link shift register.
// No chip select: spi_frame_rst held high while idle frames the responder.
module pi_spi_master
    import pi_spi_pkg::*;
#(
    parameter int WIDTH  = PI_SPI_WIDTH,
    parameter int CLKDIV = PI_SPI_CLKDIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_frame_rst
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] FULL = BW'(WIDTH);

    spi_state_t       r_state;
    logic [BW-1:0]    r_bits;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_sclk;
    logic             r_frame_rst;
    logic             r_miso_s1;
    logic             r_miso_s2;
    logic             w_done;
    logic             w_run;

    assign w_run         = (r_state != IDLE);
    assign tx_ready      = (r_state == IDLE);
    assign busy          = w_run;
    assign rx_valid      = r_rx_valid;
    assign rx_data       = r_rx_data;
    assign spi_sclk      = r_sclk;
    assign spi_mosi      = r_tx[WIDTH-1];
    assign spi_frame_rst = r_frame_rst;

    pi_spi_tick #(
        .CLKDIV (CLKDIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_run  (w_run),
        .o_done (w_done)
    );

    // Two-flop synchroniser for the responder's MISO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= spi_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Frame FSM: sclk, MOSI shift, MISO capture, completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bits      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_sclk      <= 1'b0;
            r_frame_rst <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_tx        <= tx_data;
                        r_bits      <= '0;
                        r_frame_rst <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_done) begin
                        r_sclk  <= 1'b1;
                        r_rx    <= {r_rx[WIDTH-2:0], r_miso_s2};
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_done) begin
                        r_sclk  <= 1'b0;
                        r_bits  <= r_bits + 1'b1;
                        if (r_bits != LAST) begin
                            r_tx <= {r_tx[WIDTH-2:0], 1'b0};
                        end
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (w_done) begin
                        if (r_bits == FULL) begin
                            r_frame_rst <= 1'b1;
                            r_rx_valid  <= 1'b1;
                            r_rx_data   <= r_rx;
                            r_state     <= IDLE;
                        end else begin
                            r_sclk  <= 1'b1;
                            r_rx    <= {r_rx[WIDTH-2:0], r_miso_s2};
                            r_state <= HIGH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
